// File: rtl/dbus_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// common
//   Shared data-bus types used by the initiators (page-table walker, LSU) and
//   by the memory-side responder.
//   - msize_t       : access size code (1/2/4/8 bytes)
//   - dbus_req_t    : request  (valid, addr, size, strobe, data)
//   - dbus_resp_t   : response (addr_ok, data_ok, data)
//   - rsp_state_e   : responder FSM state, exposed for debug
//   - dbus_misaligned() : natural-alignment check, shared with the LSU
// -----------------------------------------------------------------------------
package common;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } rsp_state_e;

   // True when the low address bits break natural alignment for the size.
   function automatic logic dbus_misaligned(msize_t size, logic [2:0] addr_lo);
      logic mis;
      mis = 1'b0;
      case (size)
         MSIZE2:  mis = (addr_lo[0] != 1'b0);
         MSIZE4:  mis = (addr_lo[1:0] != 2'b00);
         MSIZE8:  mis = (addr_lo != 3'b000);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/dbus_mem_responder_if.sv
// -----------------------------------------------------------------------------
// dbus_mem_responder_if
//   Data-bus request/response bundle.
//   - dreq  : request from the initiator
//   - dresp : response from the memory responder
//   Handshake: a request is accepted in any cycle where dreq.valid and
//   dresp.addr_ok are both high; the initiator holds valid and all request
//   fields stable from then until the cycle it sees dresp.data_ok, which
//   marks the single response cycle.
// -----------------------------------------------------------------------------
interface dbus_mem_responder_if;
   import common::*;

   dbus_req_t  dreq;
   dbus_resp_t dresp;

   modport master (output dreq, input dresp);
   modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_mem_responder_sram.sv
// -----------------------------------------------------------------------------
// dbus_sram
//   MEM_WORDS x 64-bit array, one asynchronous read port, one byte-strobed
//   write port and a whole-word backdoor write port. The array has no reset.
//   Ports:
//   - clk                       : write clock
//   - rd_idx_i / rd_data_o      : read port
//   - wr_en_i, wr_idx_i,
//     wr_strb_i, wr_data_i      : byte-strobed write port
//   - bd_we_i, bd_idx_i,
//     bd_data_i                 : backdoor whole-word write
// -----------------------------------------------------------------------------
module dbus_sram #(
   parameter int MEM_WORDS = 4096
) (
   input  logic                         clk,
   input  logic [$clog2(MEM_WORDS)-1:0] rd_idx_i,
   output logic [63:0]                  rd_data_o,
   input  logic                         wr_en_i,
   input  logic [$clog2(MEM_WORDS)-1:0] wr_idx_i,
   input  logic [7:0]                   wr_strb_i,
   input  logic [63:0]                  wr_data_i,
   input  logic                         bd_we_i,
   input  logic [$clog2(MEM_WORDS)-1:0] bd_idx_i,
   input  logic [63:0]                  bd_data_i
);

   logic [63:0] mem [MEM_WORDS];
   logic        collide;
   logic [63:0] merged;

   assign rd_data_o = mem[rd_idx_i];

   // Same word written by both ports in one edge: strobed lanes keep the
   // bus data, every other lane takes the backdoor word.
   assign collide = bd_we_i && wr_en_i && (bd_idx_i == wr_idx_i);

   always_comb begin
      merged = bd_data_i;
      for (int b = 0; b < 8; b++) begin
         if (wr_strb_i[b]) merged[b*8 +: 8] = wr_data_i[b*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (bd_we_i) mem[bd_idx_i] <= collide ? merged : bd_data_i;
      if (wr_en_i && !collide) begin
         for (int b = 0; b < 8; b++) begin
            if (wr_strb_i[b]) mem[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/dbus_mem_responder.sv
// -----------------------------------------------------------------------------
// dbus_mem_responder
//   Memory-side data-bus endpoint. Accepts one request at a time, answers
//   after LATENCY cycles with a single data_ok cycle, and commits writes on
//   the edge leaving the response cycle.
//   Ports:
//   - clk, reset      : clock, asynchronous active-low reset
//   - dbus (slave)    : dreq in, dresp out (addr_ok combinational, data_ok
//                       and data registered)
//   - bad_access      : high in the data_ok cycle of a misaligned or
//                       out-of-range request
//   - req_cnt         : completed-request count (wraps)
//   - bd_we/idx/data  : backdoor whole-word write
//   - dbg_state       : current FSM state
// -----------------------------------------------------------------------------
module dbus_mem_responder
   import common::*;
#(
   parameter int          MEM_WORDS = 4096,
   parameter logic [63:0] BASE      = 64'h8000_0000,
   parameter int          LATENCY   = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   dbus_mem_responder_if.slave          dbus,
   output logic                         bad_access,
   output logic [31:0]                  req_cnt,
   input  logic                         bd_we,
   input  logic [$clog2(MEM_WORDS)-1:0] bd_idx,
   input  logic [63:0]                  bd_data,
   output rsp_state_e                   dbg_state
);

   localparam int IW = $clog2(MEM_WORDS);
   localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;

   rsp_state_e  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [63:0] addr_q, addr_d;
   msize_t      size_q, size_d;
   logic [7:0]  strobe_q, strobe_d;
   logic [63:0] wdata_q, wdata_d;
   logic        data_ok_q, data_ok_d;
   logic        bad_q, bad_d;
   logic [63:0] rdata_q, rdata_d;
   logic [31:0] req_cnt_q, req_cnt_d;

   logic [63:0] cur_addr;
   msize_t      cur_size;
   logic [60:0] word_off;
   logic        in_range;
   logic        bad_req;
   logic [IW-1:0] idx;
   logic [63:0] rd_data;
   logic        wr_en;
   logic        addr_ok;

   // In IDLE the decode looks at the live bus so a LATENCY=1 response can be
   // loaded on the acceptance edge; afterwards it uses the captured request.
   always_comb begin
      cur_addr = (state_q == IDLE) ? dbus.dreq.addr : addr_q;
      cur_size = (state_q == IDLE) ? dbus.dreq.size : size_q;
   end

   // BASE is 8-byte aligned, so the word offset is a plain difference of the
   // doubleword addresses.
   assign word_off = cur_addr[63:3] - BASE[63:3];
   assign in_range = (cur_addr >= BASE) && (word_off < 61'(MEM_WORDS));
   assign bad_req  = !in_range || dbus_misaligned(cur_size, cur_addr[2:0]);
   assign idx      = word_off[IW-1:0];

   assign addr_ok  = reset && (state_q == IDLE) && dbus.dreq.valid;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      size_d    = size_q;
      strobe_d  = strobe_q;
      wdata_d   = wdata_q;
      req_cnt_d = req_cnt_q;
      data_ok_d = 1'b0;
      bad_d     = 1'b0;
      rdata_d   = '0;
      wr_en     = 1'b0;

      case (state_q)
         IDLE: begin
            if (dbus.dreq.valid) begin
               addr_d   = dbus.dreq.addr;
               size_d   = dbus.dreq.size;
               strobe_d = dbus.dreq.strobe;
               wdata_d  = dbus.dreq.data;
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CW'(LATENCY - 2);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = RESP;
            else             cnt_d   = cnt_q - CW'(1);
         end
         RESP: begin
            state_d   = IDLE;
            req_cnt_d = req_cnt_q + 32'd1;
            wr_en     = !bad_q && (strobe_q != 8'h00);
         end
         default: state_d = IDLE;
      endcase

      // Response registers load on the edge entering RESP; for a write this
      // captures the word before the commit one edge later.
      if (state_d == RESP) begin
         data_ok_d = 1'b1;
         bad_d     = bad_req;
         rdata_d   = bad_req ? 64'd0 : rd_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         size_q    <= MSIZE1;
         strobe_q  <= '0;
         wdata_q   <= '0;
         data_ok_q <= 1'b0;
         bad_q     <= 1'b0;
         rdata_q   <= '0;
         req_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         size_q    <= size_d;
         strobe_q  <= strobe_d;
         wdata_q   <= wdata_d;
         data_ok_q <= data_ok_d;
         bad_q     <= bad_d;
         rdata_q   <= rdata_d;
         req_cnt_q <= req_cnt_d;
      end
   end

   dbus_sram #(
      .MEM_WORDS (MEM_WORDS)
   ) u_sram (
      .clk       (clk),
      .rd_idx_i  (idx),
      .rd_data_o (rd_data),
      .wr_en_i   (wr_en),
      .wr_idx_i  (idx),
      .wr_strb_i (strobe_q),
      .wr_data_i (wdata_q),
      .bd_we_i   (bd_we),
      .bd_idx_i  (bd_idx),
      .bd_data_i (bd_data)
   );

   assign dbus.dresp = '{addr_ok: addr_ok, data_ok: data_ok_q, data: rdata_q};
   assign bad_access = bad_q;
   assign req_cnt    = req_cnt_q;
   assign dbg_state  = state_q;

endmodule
